serial_add_ctrl: RTL and testbench

//  Bit-serial add sequencer for the FMAC datapath. Time-shares one external
//  1-bit full-adder cell across all WIDTH bit positions, LSB first.

---
 rtl/serial_add_ctrl.sv | 164 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add sequencer. It shares one external 1-bit full-adder cell
//   across all WIDTH bit positions, least significant bit first. Operands are
//   accepted on a valid/ready handshake. Sum, carry-out and signed overflow are
//   returned on a valid/ready handshake. In accumulate mode, operand A is taken
//   from the last completed sum instead of from in_a.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE, low in reset)
//   in_a, in_b, in_cin  operands and carry into bit 0
//   in_acc              1: operand A comes from the result register
//   fa_a/fa_b/fa_cin    drive the external adder cell (0 outside RUN)
//   fa_s/fa_cout        adder cell outputs, sampled only in RUN
//   out_valid/out_ready result handshake (out_valid high in DONE)
//   out_sum             result register, also the accumulator
//   out_cout            carry out of bit WIDTH-1
//   out_ovf             signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_acc,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SSR_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_sr_q,    a_sr_d;
    logic [WIDTH-1:0] b_sr_q,    b_sr_d;
    // Partial sum bits 0..WIDTH-2. The final bit arrives from the cell on the
    // last step and is concatenated on top of these bits when out_sum loads.
    logic [SSR_W-1:0] sum_sr_q,  sum_sr_d;
    logic             carry_q,   carry_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q,  out_ovf_d;

    logic in_ready_c;
    logic accept_c;
    logic run_c;

    // Handshake decode from the state register
    always_comb begin
        in_ready_c = (state_q == ST_IDLE) & ~rst;
        accept_c   = in_valid & in_ready_c;
        run_c      = (state_q == ST_RUN);
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        sum_sr_d   = sum_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    a_sr_d   = in_acc ? out_sum_q : in_a;
                    b_sr_d   = in_b;
                    carry_d  = in_cin;
                    sum_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                // One bit position per cycle, LSB first
                sum_sr_d = SSR_W'({fa_s, sum_sr_q} >> 1);
                carry_d  = fa_cout;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    out_sum_d  = {fa_s, sum_sr_q};
                    out_cout_d = fa_cout;
                    // carry_q still holds the carry into the MSB here
                    out_ovf_d  = carry_q ^ fa_cout;
                    state_d    = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            sum_sr_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            sum_sr_q   <= sum_sr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Adder cell is fed only from registered sources, and only in RUN
    always_comb begin
        in_ready  = in_ready_c;
        out_valid = (state_q == ST_DONE);
        fa_a      = run_c & a_sr_q[0];
        fa_b      = run_c & b_sr_q[0];
        fa_cin    = run_c & carry_q;
        out_sum   = out_sum_q;
        out_cout  = out_cout_q;
        out_ovf   = out_ovf_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Bench for serial_add_ctrl (WIDTH=8). A behavioural full adder is wired to
//   the fa_* ports. Expected results come from plain integer addition on an
//   accumulator model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_acc;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] model_acc = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_acc   (in_acc),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_s     (fa_s),
        .fa_cout  (fa_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    // Behavioural full-adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One complete operation, then hold DONE for `hold` cycles before taking the result
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic acc, input int hold);
        int       n;
        int       lat;
        logic [7:0] opa;
        logic [8:0] full;
        logic       exp_ovf;
        logic [7:0] prev;
        logic [7:0] held_sum;
        logic [2:0] held_flags;

        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1 n++;
        end
        chk("idle_ready", 32'(in_ready), 32'd1);

        opa     = acc ? model_acc : a;
        full    = 9'(opa) + 9'(b) + 9'(cin);
        exp_ovf = (opa[7] == b[7]) && (full[7] != opa[7]);
        prev    = model_acc;

        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_acc = acc;
        @(posedge clk); #1;
        // Operands only matter at the accepting edge
        in_a = 8'($urandom); in_b = 8'($urandom);
        in_cin = 1'($urandom); in_acc = 1'($urandom);
        chk("run_keeps_prev_sum", 32'(out_sum), 32'(prev));

        lat = 0;
        do begin
            in_valid = 1'($urandom);
            @(posedge clk); #1 lat++;
        end while (!out_valid && lat < 20);
        chk("latency", 32'(lat), 32'd8);
        chk("sum", 32'(out_sum), 32'(full[7:0]));
        chk("cout", 32'(out_cout), 32'(full[8]));
        chk("ovf", 32'(out_ovf), 32'(exp_ovf));
        chk("done_idle_outputs", {28'd0, in_ready, fa_a, fa_b, fa_cin}, 32'd0);

        held_sum   = out_sum;
        held_flags = {out_valid, out_cout, out_ovf};
        out_ready  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_state", {12'd0, out_sum, 5'd0, out_valid, out_cout, out_ovf,
                               in_ready, fa_a, fa_b, fa_cin},
                {12'd0, held_sum, 5'd0, held_flags, 4'd0});
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
        model_acc = full[7:0];
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_acc = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_outputs", {20'd0, out_sum, out_valid, out_cout, out_ovf, in_ready},
            32'd0);
        chk("reset_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Basic add
        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
        chk("t1_const", 32'(out_sum), 32'h7F);
        // Unsigned wrap and signed overflow
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        chk("t2a_const", {23'd0, out_cout, out_sum}, 32'h100);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1);
        chk("t2b_const", {23'd0, out_ovf, out_sum}, 32'h180);
        // Accumulate chain with junk on in_a
        run_op(8'h10, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'hAA, 8'h05, 1'b0, 1'b1, 0);
        chk("t3a_const", 32'(out_sum), 32'h15);
        run_op(8'hAA, 8'h05, 1'b0, 1'b1, 0);
        chk("t3b_const", 32'(out_sum), 32'h1A);
        // Long back-pressure in DONE
        run_op(8'hAA, 8'h05, 1'b0, 1'b1, 10);
        chk("t3c_const", 32'(out_sum), 32'h1F);

        // Reset in the middle of RUN
        in_valid = 1'b1; in_a = 8'h55; in_b = 8'h22; in_cin = 1'b0; in_acc = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun_reset", {20'd0, out_sum, out_valid, in_ready, fa_a, fa_b}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("ready_after_abort", {30'd0, in_ready, out_valid}, 32'd2);
        model_acc = '0;
        run_op(8'hAA, 8'h03, 1'b0, 1'b1, 0);
        chk("t5_const", 32'(out_sum), 32'h03);

        // Carry-in and MSB boundary cases
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 0);
        chk("t6a_const", {23'd0, out_cout, out_sum}, 32'h001);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
        chk("t6b_const", {22'd0, out_ovf, out_cout, out_sum}, 32'h300);

        // Random operations, mixed accumulate and back-pressure
        for (int k = 0; k < 40; k++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
